// File: rtl/fft_frame_ctrl.sv
// Stream-side sequencer for a 128-point pipelined FFT: input framing, pad/drain flush,
// and a first-word-fall-through output buffer. Framing checks enabled by `define FFT_FRAME_CHECK_EN.
module fft_frame_ctrl #(
  parameter int LGSIZE   = 7,
  parameter int IWIDTH   = 26,
  parameter int OWIDTH   = 30,
  parameter int LGOBUF   = 2,
  parameter int LGFLIGHT = 3
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [2*IWIDTH-1:0] s_data,
  input  logic                s_last,
  input  logic                i_flush,
  output logic                o_busy,
  output logic                o_fft_reset,
  output logic                o_fft_ce,
  output logic [2*IWIDTH-1:0] o_fft_sample,
  input  logic [2*OWIDTH-1:0] i_fft_result,
  input  logic                i_fft_sync,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [2*OWIDTH-1:0] m_data,
  output logic                m_last,
  output logic                o_err
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAD   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam int unsigned   DEPTH   = 1 << LGOBUF;
  localparam logic [LGOBUF:0] DEPTH_V = (LGOBUF+1)'(DEPTH);
  localparam logic [LGOBUF:0] CNT_ONE = (LGOBUF+1)'(1);

  logic [1:0]          state, state_nxt;
  logic                fft_rst_q;
  logic [LGSIZE-1:0]   in_cnt, in_nxt, out_cnt, res_idx;
  logic [LGFLIGHT-1:0] flight;
  logic                out_started, ce_q;
  logic [LGOBUF:0]     ob_count, pend_v;
  logic [LGOBUF-1:0]   rd_ptr, wr_ptr;
  logic [2*OWIDTH:0]   mem [DEPTH];
  logic [2*OWIDTH:0]   head;

  logic res_valid, res_last, push, pop, room, drain_done;
  logic wrap, flight_inc, flight_dec;

  // A result is due whenever the previous cycle clocked the FFT after output start;
  // counting the first sync cycle too keeps the buffer from overfilling on start-up.
  assign res_valid  = ce_q && (out_started || i_fft_sync);
  assign res_idx    = i_fft_sync ? '0 : out_cnt;
  assign res_last   = &res_idx;
  assign push       = res_valid && (flight != '0);
  assign pop        = m_valid && m_ready;
  assign pend_v     = {{LGOBUF{1'b0}}, res_valid};
  assign room       = (ob_count + pend_v) < DEPTH_V;
  assign drain_done = (flight == '0) && (ob_count == '0) && (in_cnt == '0);

  always_comb begin
    s_ready  = 1'b0;
    o_fft_ce = 1'b0;
    case (state)
      S_RUN: begin
        s_ready  = room;
        o_fft_ce = s_valid && room;
      end
      S_PAD:   o_fft_ce = room;
      S_DRAIN: o_fft_ce = room && !drain_done;
      default: ;
    endcase
  end

  assign o_fft_sample = (state == S_RUN) ? s_data : '0;
  assign o_fft_reset  = fft_rst_q;
  assign o_busy       = (state != S_IDLE);

  // in_cnt keeps counting through DRAIN (without touching flight) so that the return
  // to RUN lands on an FFT frame boundary.
  assign in_nxt     = in_cnt + LGSIZE'(o_fft_ce);
  assign wrap       = o_fft_ce && (&in_cnt);
  assign flight_inc = wrap && (state != S_DRAIN);
  assign flight_dec = push && res_last;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!fft_rst_q) state_nxt = S_RUN;
      S_RUN:   if (i_flush) state_nxt = (in_nxt != '0) ? S_PAD : S_DRAIN;
      S_PAD:   if (wrap) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_done) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= S_IDLE;
      fft_rst_q   <= 1'b1;
      in_cnt      <= '0;
      out_cnt     <= '0;
      flight      <= '0;
      out_started <= 1'b0;
      ce_q        <= 1'b0;
    end else begin
      state     <= state_nxt;
      fft_rst_q <= 1'b0;
      in_cnt    <= in_nxt;
      ce_q      <= o_fft_ce;
      if (ce_q && i_fft_sync) out_started <= 1'b1;
      if (res_valid) out_cnt <= res_idx + LGSIZE'(1);
      if (flight_inc && !flight_dec)
        flight <= flight + LGFLIGHT'(1);
      else if (!flight_inc && flight_dec)
        flight <= flight - LGFLIGHT'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      ob_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + LGOBUF'(1);
      if (pop)  rd_ptr <= rd_ptr + LGOBUF'(1);
      case ({push, pop})
        2'b10:   ob_count <= ob_count + CNT_ONE;
        2'b01:   ob_count <= ob_count - CNT_ONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= {res_last, i_fft_result};
  end

  assign head    = mem[rd_ptr];
  assign m_valid = (ob_count != '0);
  assign m_data  = head[2*OWIDTH-1:0];
  assign m_last  = m_valid && head[2*OWIDTH];

`ifdef FFT_FRAME_CHECK_EN
  logic err_q;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      err_q <= 1'b0;
    else if ((s_valid && s_ready && (s_last ^ (&in_cnt))) ||
             (flight_inc && !flight_dec && (&flight)))
      err_q <= 1'b1;
  end
  assign o_err = err_q;
`else
  logic unused_last;
  assign unused_last = s_last;
  assign o_err       = 1'b0;
`endif

endmodule
